qpi_tx_arbiter: RTL and testbench
=================================

# qpi_tx_arbiter

Parametrised N-client request arbiter between frame readers, frame writers and status logic and the CCI transmit channels. It grants at most one read per cycle onto TX channel 0 and one write per cycle onto TX channel 1, with round-robin fairness and almost-full backpressure. It tags each request's mdata with the client index and routes RX responses back to the issuing client. Per-channel outstanding-credit limits are enforced, and WrFence requests are held until all prior writes have completed.

## Interface
- N_CLIENTS, 4, number of requesters (2..16)
- IDX_W, $clog2(N_CLIENTS), client-index bits placed in mdata[13:14-IDX_W]
- MAX_RD_OUT, 64, maximum outstanding reads on channel 0
- MAX_WR_OUT, 64, maximum outstanding writes (WrThru/WrLine)
- clk  in  1  sole clock
- resetb  in  1  asynchronous, active-low reset
- rd_req  in  N_CLIENTS  per-client read request, level; held until granted
- rd_addr  in  N_CLIENTS*32  per-client cache-line address
- rd_mdata  in  N_CLIENTS*(14-IDX_W)  per-client metadata
- rd_grant  out  N_CLIENTS  one-hot, combinational; request is consumed in this cycle
- wr_req  in  N_CLIENTS  per-client write request
- wr_type  in  N_CLIENTS*4  tx_request_t encoding: WrThru=1, WrLine=2, WrFence=5
- wr_addr, wr_mdata, wr_data  in  N*32, N*(14-IDX_W), N*512  write payload
- wr_grant  out  N_CLIENTS  one-hot, combinational
- tx0_header  out  61  tx_header_t; tx0_rdvalid out 1; tx0_almostfull in 1
- tx1_header  out  61; tx1_data out 512; tx1_wrvalid out 1; tx1_almostfull in 1
- rx0_header  in  18; rx0_rdvalid in 1; rx0_wrvalid in 1; rx1_header in 18; rx1_wrvalid in 1
- rd_rsp_valid  out  N_CLIENTS  one-hot routing of rx0_rdvalid, combinational
- wr_rsp_valid0, wr_rsp_valid1  out  N_CLIENTS each  routing of rx0_wrvalid / rx1_wrvalid
- err_underflow  out  1  sticky; set when a response arrives with a zero outstanding count

## Operation
- There are two independent arbiters (read, write), each with a registered round-robin pointer. The search starts at pointer+1. After a grant, the pointer is set to the granted index.
- Read eligibility: rd_req[i] && !tx0_almostfull && rd_out < MAX_RD_OUT.
- Write eligibility for WrThru/WrLine: wr_req[i] && !tx1_almostfull && wr_out < MAX_WR_OUT.
- Write eligibility for WrFence: wr_req[i] && !tx1_almostfull && wr_out == 0 && no write is granted in the same cycle. A fence that is not eligible is skipped; the other clients are still arbitrated.
- Header construction:
  - byte_enable = 0, rsvd = 0
  - address = client addr
  - mdata = {client index, client mdata}
  - request_type = RdLine on channel 0, client wr_type on channel 1
- Counters:
  - rd_out: +1 on read grant, −1 on rx0_rdvalid.
  - wr_out: +1 on a WrThru/WrLine grant; −1 for each of rx0_wrvalid and rx1_wrvalid, so the net change can be −2..+1 in one cycle. Fences do not count.
  - Counter width is $clog2(MAX+1).
  - A decrement below 0 saturates at 0 and sets err_underflow.
- Response routing: the client index is taken from header[13:14-IDX_W] of the corresponding RX header. Responses are never dropped or stalled.
- Unknown wr_type values (not 1, 2 or 5) are treated as WrLine.

## Timing
- Grant is combinational in cycle t. tx0/tx1 header, data and valid are registered and appear in cycle t+1, with valid for exactly one cycle per grant.
- almostfull is sampled combinationally. A grant is suppressed in any cycle where almostfull=1; requests issued in the already-registered t+1 slot are accepted by the channel (the almostfull margin covers this).
- A counter increment is visible to eligibility in cycle t+1, so back-to-back grants up to MAX are allowed and the (MAX+1)th is blocked.
- A response arriving in the same cycle as a grant: the net counter update is applied in one step. A credit returned in cycle t enables a grant in t+1.
- Reset (asynchronous, any time, including mid-burst):
  - tx0_rdvalid = 0, tx1_wrvalid = 0
  - headers and data = 0
  - grants = 0 while resetb = 0
  - counters = 0, pointers = N_CLIENTS−1 (so client 0 has first priority), err_underflow = 0
- In-flight responses after reset may set err_underflow; this is expected.

## Test plan
- All 4 clients hold rd_req, almostfull=0 → grants go 0,1,2,3,0 on consecutive cycles; tx0_header.mdata[13:12] = 0,1,2,3,0 one cycle after each grant.
- MAX_RD_OUT=4, no responses, client 2 holds rd_req → exactly 4 grants, then none. One rx0_rdvalid with mdata[13:12]=2 → rd_rsp_valid=4'b0100, and one new grant the next cycle.
- tx1_almostfull=1 for 5 cycles with wr_req=4'b1111 → no wr_grant and tx1_wrvalid=0 throughout. Deassert → grant to client 0 in the same cycle.
- Client 1 issues WrLine ×3, then client 3 issues WrFence → fence is held while wr_out=3. rx0_wrvalid and rx1_wrvalid arrive in the same cycle (wr_out=1), then one more → fence is granted the next cycle with tx1_header.request_type=4'h5.
- rx0_rdvalid with rd_out=0 → err_underflow=1 and rd_out stays 0. Assert resetb=0 mid-burst → tx0_rdvalid=0 immediately and err_underflow clears.

Source files
------------

// File: rtl/qpi_tx_arbiter.sv
// Round-robin arbiter from N clients onto CCI TX0 (reads) / TX1 (writes), mdata tagged with client index; RX responses routed back.
// Latency: grant combinational in cycle t, TX header/data/valid registered in t+1; response routing is combinational.
// Backpressure: almostfull or exhausted outstanding credits suppress grants; fences wait for all writes to drain.
module qpi_tx_arbiter #(
    parameter int N_CLIENTS  = 4,
    parameter int IDX_W      = $clog2(N_CLIENTS),
    parameter int MAX_RD_OUT = 64,
    parameter int MAX_WR_OUT = 64
) (
    input  logic                              clk,
    input  logic                              resetb,
    input  logic [N_CLIENTS-1:0]              rd_req,
    input  logic [N_CLIENTS*32-1:0]           rd_addr,
    input  logic [N_CLIENTS*(14-IDX_W)-1:0]   rd_mdata,
    output logic [N_CLIENTS-1:0]              rd_grant,
    input  logic [N_CLIENTS-1:0]              wr_req,
    input  logic [N_CLIENTS*4-1:0]            wr_type,
    input  logic [N_CLIENTS*32-1:0]           wr_addr,
    input  logic [N_CLIENTS*(14-IDX_W)-1:0]   wr_mdata,
    input  logic [N_CLIENTS*512-1:0]          wr_data,
    output logic [N_CLIENTS-1:0]              wr_grant,
    output logic [60:0]                       tx0_header,
    output logic                              tx0_rdvalid,
    input  logic                              tx0_almostfull,
    output logic [60:0]                       tx1_header,
    output logic [511:0]                      tx1_data,
    output logic                              tx1_wrvalid,
    input  logic                              tx1_almostfull,
    input  logic [17:0]                       rx0_header,
    input  logic                              rx0_rdvalid,
    input  logic                              rx0_wrvalid,
    input  logic [17:0]                       rx1_header,
    input  logic                              rx1_wrvalid,
    output logic [N_CLIENTS-1:0]              rd_rsp_valid,
    output logic [N_CLIENTS-1:0]              wr_rsp_valid0,
    output logic [N_CLIENTS-1:0]              wr_rsp_valid1,
    output logic                              err_underflow
);

    localparam int MD_W  = 14 - IDX_W;
    localparam int RD_CW = $clog2(MAX_RD_OUT + 1);
    localparam int WR_CW = $clog2(MAX_WR_OUT + 1);

    localparam logic [3:0] REQ_WRTHRU  = 4'h1;
    localparam logic [3:0] REQ_WRLINE  = 4'h2;
    localparam logic [3:0] REQ_RDLINE  = 4'h4;
    localparam logic [3:0] REQ_WRFENCE = 4'h5;

    localparam logic [RD_CW-1:0]     RD_MAX = RD_CW'(MAX_RD_OUT);
    localparam logic [WR_CW-1:0]     WR_MAX = WR_CW'(MAX_WR_OUT);
    localparam logic [N_CLIENTS-1:0] LSB    = N_CLIENTS'(1);
    localparam logic [IDX_W-1:0]     PTR_RST = IDX_W'(N_CLIENTS - 1);

    typedef struct packed {
        logic [4:0]  rsvd;
        logic [3:0]  request_type;
        logic [5:0]  byte_enable;
        logic [31:0] address;
        logic [13:0] mdata;
    } tx_header_t;

    logic [31:0]      rd_addr_a  [N_CLIENTS];
    logic [MD_W-1:0]  rd_md_a    [N_CLIENTS];
    logic [31:0]      wr_addr_a  [N_CLIENTS];
    logic [MD_W-1:0]  wr_md_a    [N_CLIENTS];
    logic [511:0]     wr_data_a  [N_CLIENTS];
    logic [3:0]       wr_type_a  [N_CLIENTS];
    logic [N_CLIENTS-1:0] wr_is_fence;

    logic [IDX_W-1:0] rd_ptr, wr_ptr;
    logic [RD_CW-1:0] rd_out, rd_out_nxt;
    logic [WR_CW-1:0] wr_out, wr_out_nxt;
    logic             rd_uf, wr_uf;

    logic [N_CLIENTS-1:0] rd_elig, wr_elig_reg, wr_elig_fen;
    logic [IDX_W:0]       rd_pick, wr_pick;
    logic [IDX_W-1:0]     rd_sel, wr_sel;
    logic                 rd_fire, wr_fire, wr_inc;
    tx_header_t           rd_hdr_nxt, wr_hdr_nxt, tx0_hdr_q, tx1_hdr_q;
    logic [RD_CW:0]       rd_sum;
    logic [WR_CW+1:0]     wr_sum, wr_dec;

    // First eligible client scanning from ptr+1 upward, wrapping at N_CLIENTS.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_CLIENTS-1:0] elig,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int k = N_CLIENTS; k >= 1; k--) begin
            j = int'(ptr) + k;
            if (j >= N_CLIENTS) j = j - N_CLIENTS;
            if (elig[IDX_W'(j)]) res = {1'b1, IDX_W'(j)};
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            rd_addr_a[i] = rd_addr[i*32 +: 32];
            rd_md_a[i]   = rd_mdata[i*MD_W +: MD_W];
            wr_addr_a[i] = wr_addr[i*32 +: 32];
            wr_md_a[i]   = wr_mdata[i*MD_W +: MD_W];
            wr_data_a[i] = wr_data[i*512 +: 512];
            // Unrecognised encodings go out as plain line writes.
            case (wr_type[i*4 +: 4])
                REQ_WRTHRU, REQ_WRLINE, REQ_WRFENCE: wr_type_a[i] = wr_type[i*4 +: 4];
                default:                             wr_type_a[i] = REQ_WRLINE;
            endcase
            wr_is_fence[i] = (wr_type_a[i] == REQ_WRFENCE);
        end
    end

    always_comb begin
        rd_elig     = rd_req & {N_CLIENTS{!tx0_almostfull && (rd_out < RD_MAX)}};
        wr_elig_reg = wr_req & ~wr_is_fence & {N_CLIENTS{!tx1_almostfull && (wr_out < WR_MAX)}};
        // A fence only competes when the write channel is fully drained and no ordinary write wants it.
        wr_elig_fen = wr_req & wr_is_fence &
                      {N_CLIENTS{!tx1_almostfull && (wr_out == '0) && (wr_elig_reg == '0)}};
        rd_pick = rr_pick(rd_elig, rd_ptr);
        wr_pick = rr_pick(wr_elig_reg | wr_elig_fen, wr_ptr);
        rd_sel  = rd_pick[IDX_W-1:0];
        wr_sel  = wr_pick[IDX_W-1:0];
        rd_fire = rd_pick[IDX_W] && resetb;
        wr_fire = wr_pick[IDX_W] && resetb;
        wr_inc  = wr_fire && !wr_is_fence[wr_sel];
    end

    assign rd_grant = rd_fire ? (LSB << rd_sel) : '0;
    assign wr_grant = wr_fire ? (LSB << wr_sel) : '0;

    always_comb begin
        rd_hdr_nxt              = '0;
        rd_hdr_nxt.request_type = REQ_RDLINE;
        rd_hdr_nxt.address      = rd_addr_a[rd_sel];
        rd_hdr_nxt.mdata        = {rd_sel, rd_md_a[rd_sel]};
        wr_hdr_nxt              = '0;
        wr_hdr_nxt.request_type = wr_type_a[wr_sel];
        wr_hdr_nxt.address      = wr_addr_a[wr_sel];
        wr_hdr_nxt.mdata        = {wr_sel, wr_md_a[wr_sel]};
    end

    // Net counter update in one step; going below zero clamps and flags an error.
    always_comb begin
        rd_uf      = 1'b0;
        rd_sum     = {1'b0, rd_out} + {{RD_CW{1'b0}}, rd_fire};
        rd_out_nxt = RD_CW'(rd_sum);
        if (rx0_rdvalid) begin
            if (rd_sum == '0) rd_uf = 1'b1;
            else              rd_out_nxt = RD_CW'(rd_sum - {{RD_CW{1'b0}}, 1'b1});
        end

        wr_uf      = 1'b0;
        wr_sum     = {2'b00, wr_out} + {{(WR_CW+1){1'b0}}, wr_inc};
        wr_dec     = {{(WR_CW+1){1'b0}}, rx0_wrvalid} + {{(WR_CW+1){1'b0}}, rx1_wrvalid};
        wr_out_nxt = WR_CW'(wr_sum - wr_dec);
        if (wr_sum < wr_dec) begin
            wr_uf      = 1'b1;
            wr_out_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rd_ptr        <= PTR_RST;
            wr_ptr        <= PTR_RST;
            rd_out        <= '0;
            wr_out        <= '0;
            err_underflow <= 1'b0;
            tx0_rdvalid   <= 1'b0;
            tx1_wrvalid   <= 1'b0;
            tx0_hdr_q     <= '0;
            tx1_hdr_q     <= '0;
            tx1_data      <= '0;
        end else begin
            rd_out      <= rd_out_nxt;
            wr_out      <= wr_out_nxt;
            tx0_rdvalid <= rd_fire;
            tx1_wrvalid <= wr_fire;
            if (rd_uf || wr_uf) err_underflow <= 1'b1;
            if (rd_fire) begin
                rd_ptr    <= rd_sel;
                tx0_hdr_q <= rd_hdr_nxt;
            end
            if (wr_fire) begin
                wr_ptr    <= wr_sel;
                tx1_hdr_q <= wr_hdr_nxt;
                tx1_data  <= wr_data_a[wr_sel];
            end
        end
    end

    assign tx0_header = tx0_hdr_q;
    assign tx1_header = tx1_hdr_q;

    assign rd_rsp_valid  = rx0_rdvalid ? (LSB << rx0_header[13:14-IDX_W]) : '0;
    assign wr_rsp_valid0 = rx0_wrvalid ? (LSB << rx0_header[13:14-IDX_W]) : '0;
    assign wr_rsp_valid1 = rx1_wrvalid ? (LSB << rx1_header[13:14-IDX_W]) : '0;

    logic unused_rx_bits;
    assign unused_rx_bits = ^{rx0_header[17:14], rx0_header[13-IDX_W:0],
                              rx1_header[17:14], rx1_header[13-IDX_W:0]};

endmodule

// File: tb/tb_qpi_tx_arbiter.sv
// Directed bench for qpi_tx_arbiter with a per-cycle reference model and literal spot checks.
module tb_qpi_tx_arbiter;
    localparam int N   = 4;
    localparam int MW  = 12;
    localparam int MRD = 4;
    localparam int MWR = 4;

    logic           clk, resetb;
    logic [N-1:0]   rd_req, rd_grant, wr_req, wr_grant;
    logic [N*32-1:0] rd_addr, wr_addr;
    logic [N*MW-1:0] rd_mdata, wr_mdata;
    logic [N*4-1:0]  wr_type;
    logic [N*512-1:0] wr_data;
    logic [60:0]    tx0_header, tx1_header;
    logic [511:0]   tx1_data;
    logic           tx0_rdvalid, tx0_almostfull, tx1_wrvalid, tx1_almostfull;
    logic [17:0]    rx0_header, rx1_header;
    logic           rx0_rdvalid, rx0_wrvalid, rx1_wrvalid;
    logic [N-1:0]   rd_rsp_valid, wr_rsp_valid0, wr_rsp_valid1;
    logic           err_underflow;

    qpi_tx_arbiter #(.N_CLIENTS(N), .MAX_RD_OUT(MRD), .MAX_WR_OUT(MWR)) dut (
        .clk(clk), .resetb(resetb),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_mdata(rd_mdata), .rd_grant(rd_grant),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_mdata(wr_mdata),
        .wr_data(wr_data), .wr_grant(wr_grant),
        .tx0_header(tx0_header), .tx0_rdvalid(tx0_rdvalid), .tx0_almostfull(tx0_almostfull),
        .tx1_header(tx1_header), .tx1_data(tx1_data), .tx1_wrvalid(tx1_wrvalid),
        .tx1_almostfull(tx1_almostfull),
        .rx0_header(rx0_header), .rx0_rdvalid(rx0_rdvalid), .rx0_wrvalid(rx0_wrvalid),
        .rx1_header(rx1_header), .rx1_wrvalid(rx1_wrvalid),
        .rd_rsp_valid(rd_rsp_valid), .wr_rsp_valid0(wr_rsp_valid0), .wr_rsp_valid1(wr_rsp_valid1),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_rd_out, m_wr_out, m_rd_ptr, m_wr_ptr;
    bit         m_err, m_tx0_v, m_tx1_v;
    logic [60:0]  m_tx0_h, m_tx1_h;
    logic [511:0] m_tx1_d;

    function automatic int pick(input logic [N-1:0] el, input int ptr);
        for (int k = 1; k <= N; k++)
            if (el[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [3:0] eff_type(input logic [3:0] t);
        return (t == 4'h1 || t == 4'h2 || t == 4'h5) ? t : 4'h2;
    endfunction

    always @(negedge clk) begin : model
        logic [N-1:0] el_rd, el_wr, el_fen, e_rdg, e_wrg, e_rr, e_w0, e_w1;
        logic [3:0]   gt;
        int           gr, gw, inc;
        if (!resetb) begin
            m_rd_out = 0; m_wr_out = 0; m_rd_ptr = N - 1; m_wr_ptr = N - 1;
            m_err = 0; m_tx0_v = 0; m_tx1_v = 0;
        end
        el_rd = '0; el_wr = '0; el_fen = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_req[i] && !tx0_almostfull && m_rd_out < MRD) el_rd[i] = 1'b1;
            if (wr_req[i] && !tx1_almostfull && eff_type(wr_type[i*4 +: 4]) != 4'h5 && m_wr_out < MWR)
                el_wr[i] = 1'b1;
        end
        for (int i = 0; i < N; i++)
            if (wr_req[i] && !tx1_almostfull && eff_type(wr_type[i*4 +: 4]) == 4'h5 &&
                m_wr_out == 0 && el_wr == '0) el_fen[i] = 1'b1;
        gr = resetb ? pick(el_rd, m_rd_ptr) : -1;
        gw = resetb ? pick(el_wr | el_fen, m_wr_ptr) : -1;
        e_rdg = (gr >= 0) ? 4'(1 << gr) : 4'b0;
        e_wrg = (gw >= 0) ? 4'(1 << gw) : 4'b0;
        e_rr  = rx0_rdvalid ? 4'(1 << rx0_header[13:12]) : 4'b0;
        e_w0  = rx0_wrvalid ? 4'(1 << rx0_header[13:12]) : 4'b0;
        e_w1  = rx1_wrvalid ? 4'(1 << rx1_header[13:12]) : 4'b0;

        chk("m_rd_grant", rd_grant, e_rdg);
        chk("m_wr_grant", wr_grant, e_wrg);
        chk("m_rd_rsp", rd_rsp_valid, e_rr);
        chk("m_wr_rsp0", wr_rsp_valid0, e_w0);
        chk("m_wr_rsp1", wr_rsp_valid1, e_w1);
        chk("m_tx0_valid", tx0_rdvalid, m_tx0_v);
        chk("m_tx1_valid", tx1_wrvalid, m_tx1_v);
        chk("m_err", err_underflow, m_err);
        if (m_tx0_v) chk("m_tx0_header", tx0_header, m_tx0_h);
        if (m_tx1_v) begin
            chk("m_tx1_header", tx1_header, m_tx1_h);
            chk("m_tx1_data", tx1_data, m_tx1_d);
        end

        if (resetb) begin
            m_tx0_v = (gr >= 0);
            if (gr >= 0) begin
                m_rd_ptr = gr;
                m_tx0_h  = {5'd0, 4'h4, 6'd0, rd_addr[gr*32 +: 32], 2'(gr), rd_mdata[gr*MW +: MW]};
            end
            m_rd_out = m_rd_out + (gr >= 0 ? 1 : 0) - (rx0_rdvalid ? 1 : 0);
            if (m_rd_out < 0) begin m_rd_out = 0; m_err = 1; end

            m_tx1_v = (gw >= 0);
            inc = 0;
            if (gw >= 0) begin
                gt       = eff_type(wr_type[gw*4 +: 4]);
                m_wr_ptr = gw;
                m_tx1_h  = {5'd0, gt, 6'd0, wr_addr[gw*32 +: 32], 2'(gw), wr_mdata[gw*MW +: MW]};
                m_tx1_d  = wr_data[gw*512 +: 512];
                inc      = (gt != 4'h5) ? 1 : 0;
            end
            m_wr_out = m_wr_out + inc - (rx0_wrvalid ? 1 : 0) - (rx1_wrvalid ? 1 : 0);
            if (m_wr_out < 0) begin m_wr_out = 0; m_err = 1; end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    task automatic do_reset();
        rd_req = '0; wr_req = '0; rx0_rdvalid = 0; rx0_wrvalid = 0; rx1_wrvalid = 0;
        tx0_almostfull = 0; tx1_almostfull = 0;
        resetb = 0;
        smp(); nxt(); nxt();
        resetb = 1;
    endtask

    logic [3:0] g1 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] i1 [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] g2 [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] g5 [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001};

    initial begin
        resetb = 1; rd_req = '0; wr_req = '0; wr_type = '0;
        tx0_almostfull = 0; tx1_almostfull = 0;
        rx0_header = '0; rx1_header = '0; rx0_rdvalid = 0; rx0_wrvalid = 0; rx1_wrvalid = 0;
        for (int i = 0; i < N; i++) begin
            rd_addr[i*32 +: 32]   = 32'h1000_0000 + 32'(i);
            rd_mdata[i*MW +: MW]  = 12'hA00 + 12'(i);
            wr_addr[i*32 +: 32]   = 32'h2000_0000 + 32'(i * 16);
            wr_mdata[i*MW +: MW]  = 12'h500 + 12'(i);
            wr_data[i*512 +: 512] = {16{32'hD000_0000 + 32'(i)}};
        end
        #2 resetb = 0;
        rd_req = 4'hF;
        smp();
        chk("rst_rd_grant", rd_grant, 4'b0);
        chk("rst_tx0_valid", tx0_rdvalid, 1'b0);
        chk("rst_tx1_valid", tx1_wrvalid, 1'b0);
        chk("rst_tx0_header", tx0_header, 61'd0);
        chk("rst_tx1_header", tx1_header, 61'd0);
        chk("rst_tx1_data", tx1_data, 512'd0);
        chk("rst_err", err_underflow, 1'b0);
        nxt();
        resetb = 1;

        // Round robin across four held requests, one response in the 4th cycle.
        for (int k = 0; k < 6; k++) begin
            rx0_rdvalid = (k == 3);
            if (k == 5) rd_req = '0;
            smp();
            if (k < 5) chk("t1_grant", rd_grant, g1[k]);
            if (k == 3) chk("t1_rsp", rd_rsp_valid, 4'b0001);
            if (k >= 1) begin
                chk("t1_tx0_valid", tx0_rdvalid, 1'b1);
                chk("t1_tx0_idx", tx0_header[13:12], i1[k-1]);
            end
            nxt();
        end
        rx0_rdvalid = 0;
        do_reset();

        // Read credit limit for a single client, then one credit back.
        rd_req = 4'b0100;
        for (int k = 0; k < 7; k++) begin
            smp(); chk("t2_grant", rd_grant, g2[k]); nxt();
        end
        rx0_rdvalid = 1; rx0_header = 18'h02000;
        smp();
        chk("t2_rsp", rd_rsp_valid, 4'b0100);
        chk("t2_grant_blocked", rd_grant, 4'b0000);
        nxt();
        rx0_rdvalid = 0;
        smp(); chk("t2_grant_after_credit", rd_grant, 4'b0100); nxt();
        smp();
        chk("t2_grant_full_again", rd_grant, 4'b0000);
        chk("t2_rdline_type", tx0_header[55:52], 4'h4);
        chk("t2_mdata", tx0_header[13:0], 14'h2A02);
        nxt();
        do_reset();

        // Write almostfull hold-off; client 0 carries an unknown type.
        tx1_almostfull = 1; wr_req = 4'hF; wr_type = {4'h2, 4'h2, 4'h2, 4'hB};
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("t3_grant_af", wr_grant, 4'b0);
            chk("t3_valid_af", tx1_wrvalid, 1'b0);
            nxt();
        end
        tx1_almostfull = 0;
        smp(); chk("t3_grant_release", wr_grant, 4'b0001); nxt();
        wr_req = '0;
        smp();
        chk("t3_tx1_valid", tx1_wrvalid, 1'b1);
        chk("t3_unknown_as_wrline", tx1_header[55:52], 4'h2);
        chk("t3_tx1_data", tx1_data, {16{32'hD000_0000}});
        nxt();
        do_reset();

        // Fence waits for three WrLines to complete.
        wr_type = {4'h5, 4'h2, 4'h2, 4'h2}; wr_req = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            smp(); chk("t4_wrline_grant", wr_grant, 4'b0010); nxt();
        end
        wr_req = 4'b1000;
        for (int k = 0; k < 2; k++) begin
            smp(); chk("t4_fence_held", wr_grant, 4'b0); nxt();
        end
        rx0_wrvalid = 1; rx1_wrvalid = 1; rx0_header = 18'h01000; rx1_header = 18'h01000;
        smp();
        chk("t4_fence_held_rsp", wr_grant, 4'b0);
        chk("t4_rsp0", wr_rsp_valid0, 4'b0010);
        chk("t4_rsp1", wr_rsp_valid1, 4'b0010);
        nxt();
        rx1_wrvalid = 0;
        smp(); chk("t4_fence_held_one", wr_grant, 4'b0); nxt();
        rx0_wrvalid = 0;
        smp(); chk("t4_fence_grant", wr_grant, 4'b1000); nxt();
        wr_req = '0;
        smp();
        chk("t4_fence_valid", tx1_wrvalid, 1'b1);
        chk("t4_fence_type", tx1_header[55:52], 4'h5);
        chk("t4_fence_idx", tx1_header[13:12], 2'd3);
        nxt();

        // Underflow on an unexpected read response, then counter still saturated at zero.
        rx0_rdvalid = 1; rx0_header = 18'h0;
        smp(); chk("t5_err_before", err_underflow, 1'b0); nxt();
        rx0_rdvalid = 0; rd_req = 4'b0001;
        for (int k = 0; k < 7; k++) begin
            rx0_rdvalid = (k == 5);
            smp();
            if (k == 0) chk("t5_err_set", err_underflow, 1'b1);
            chk("t5_grant", rd_grant, g5[k]);
            nxt();
        end
        rx0_rdvalid = 0;
        // Asynchronous reset while a read is on the channel.
        resetb = 0;
        smp();
        chk("t5_rst_tx0_valid", tx0_rdvalid, 1'b0);
        chk("t5_rst_err", err_underflow, 1'b0);
        chk("t5_rst_grant", rd_grant, 4'b0);
        nxt();
        resetb = 1; rd_req = '0;
        repeat (3) nxt();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end
endmodule
